// File: rtl/keystroke_uart_rx_if.sv
// Serial-side bundle of the keystroke receiver: the RX pin in, the decoded byte and strobes out.
// Keystroke_Valid and Framing_Error are one-cycle strobes with no ready: the consumer must
// capture Keystroke in the Keystroke_Valid cycle; Keystroke then holds until the next good frame.
interface keystroke_uart_rx_if;
  logic       RX;
  logic [7:0] Keystroke;
  logic       Keystroke_Valid;
  logic       Framing_Error;

  modport master (
    output RX,
    input  Keystroke,
    input  Keystroke_Valid,
    input  Framing_Error
  );

  modport slave (
    input  RX,
    output Keystroke,
    output Keystroke_Valid,
    output Framing_Error
  );
endinterface

// File: rtl/keystroke_uart_rx.sv
// UART 8N1 receiver: synchronises RX, samples mid-bit and presents the last good byte
// as a held level plus one-cycle valid / framing-error strobes.
module keystroke_uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                 CLK,
  input  logic                 RST,
  keystroke_uart_rx_if.slave   uart,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_key;
  logic          r_valid;
  logic          r_ferr;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_key_nxt;
  logic          w_valid_nxt;
  logic          w_ferr_nxt;

  // Strobes are registered, so they appear the cycle after the stop sample,
  // which is also the first cycle back in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_key_nxt   = r_key;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = r_rx_s;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_key_nxt   = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Synchroniser flops reset high so a reset never looks like a start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_key   <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= uart.RX;
      r_rx_s  <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_key   <= w_key_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign uart.Keystroke       = r_key;
  assign uart.Keystroke_Valid = r_valid;
  assign uart.Framing_Error   = r_ferr;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_keystroke_uart_rx.sv
// Directed bench for keystroke_uart_rx at 8 clocks per bit; a negedge monitor logs every
// strobe with its cycle stamp and each scenario task checks the log against hand-derived values.
module tb_keystroke_uart_rx;
  localparam int CPB = 8;
  localparam int LAT = 79;   // RX falling edge to visible strobe
  localparam int FRM = 80;   // one 8N1 frame

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int both_cnt = 0;

  int         val_cyc_q[$];
  logic [7:0] val_dat_q[$];
  int         fe_cyc_q[$];

  keystroke_uart_rx_if u_if ();

  keystroke_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK         (clk),
    .RST         (rst),
    .uart        (u_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (u_if.Keystroke_Valid === 1'b1) begin
      val_cyc_q.push_back(cyc);
      val_dat_q.push_back(u_if.Keystroke);
    end
    if (u_if.Framing_Error === 1'b1) fe_cyc_q.push_back(cyc);
    if (u_if.Keystroke_Valid === 1'b1 && u_if.Framing_Error === 1'b1) both_cnt++;
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    val_cyc_q.delete();
    val_dat_q.delete();
    fe_cyc_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.RX = bits[i];
      wait_cycles(CPB);
    end
    u_if.RX = 1'b1;
  endtask

  task automatic check_valid(input string name, input int idx, input int exp_cyc,
                             input logic [7:0] exp_dat);
    n_tests++;
    if (idx >= val_cyc_q.size()) begin
      n_fail++;
      $display("FAIL %s: pulse %0d missing, got %0d pulses required at least %0d",
               name, idx, val_cyc_q.size(), idx + 1);
    end else if (val_cyc_q[idx] !== exp_cyc || val_dat_q[idx] !== exp_dat) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d data %h, required cycle %0d data %h",
               name, val_cyc_q[idx], val_dat_q[idx], exp_cyc, exp_dat);
    end
  endtask

  // scenarios
  task automatic test_reset();
    u_if.RX = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({u_if.Keystroke, u_if.Keystroke_Valid, u_if.Framing_Error} !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_outputs: got key %h v %b fe %b, required 00 0 0",
                 u_if.Keystroke, u_if.Keystroke_Valid, u_if.Framing_Error);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    wait_cycles(200);
    n_tests++;
    if (val_cyc_q.size() + fe_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d strobes, required 0", val_cyc_q.size() + fe_cyc_q.size());
    end
    n_tests++;
    if (u_if.Keystroke !== 8'h00 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got key %h state %0d, required 00 state 0", u_if.Keystroke, dbg_state);
    end
  endtask

  task automatic test_single();
    int t0;
    clear_log();
    t0 = cyc;
    send_frame(8'h31, 1'b1);
    wait_cycles(16);
    n_tests++;
    if (val_cyc_q.size() !== 1 || fe_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL single_count: got %0d valid %0d ferr, required 1 valid 0 ferr",
               val_cyc_q.size(), fe_cyc_q.size());
    end
    check_valid("single_pulse", 0, t0 + LAT, 8'h31);
    n_tests++;
    if (u_if.Keystroke !== 8'h31) begin
      n_fail++;
      $display("FAIL single_hold: got %h, required 31", u_if.Keystroke);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [7:0] exp_q[$];
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h41};
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1);
    wait_cycles(16);
    n_tests++;
    if (val_cyc_q.size() !== 4 || fe_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d valid %0d ferr, required 4 valid 0 ferr",
               val_cyc_q.size(), fe_cyc_q.size());
    end
    for (int i = 0; i < 4; i++) check_valid("b2b_pulse", i, t0 + LAT + i * FRM, exp_q[i]);
    n_tests++;
    if (u_if.Keystroke !== 8'h41) begin
      n_fail++;
      $display("FAIL b2b_hold: got %h, required 41", u_if.Keystroke);
    end
  endtask

  task automatic test_glitch();
    int t0;
    clear_log();
    u_if.RX = 1'b0;
    wait_cycles(2);
    u_if.RX = 1'b1;
    wait_cycles(40);
    n_tests++;
    if (val_cyc_q.size() + fe_cyc_q.size() !== 0 || u_if.Keystroke !== 8'h41 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch_reject: got %0d strobes key %h state %0d, required 0 strobes key 41 state 0",
               val_cyc_q.size() + fe_cyc_q.size(), u_if.Keystroke, dbg_state);
    end
    t0 = cyc;
    send_frame(8'h32, 1'b1);
    wait_cycles(16);
    check_valid("glitch_after", 0, t0 + LAT, 8'h32);
  endtask

  task automatic test_framing();
    int t1, t2, t3;
    clear_log();
    t1 = cyc;
    send_frame(8'h31, 1'b1);
    t2 = cyc;
    send_frame(8'h55, 1'b0);
    wait_cycles(16);
    n_tests++;
    if (fe_cyc_q.size() !== 1 || val_cyc_q.size() !== 1) begin
      n_fail++;
      $display("FAIL ferr_count: got %0d ferr %0d valid, required 1 ferr 1 valid",
               fe_cyc_q.size(), val_cyc_q.size());
    end else if (fe_cyc_q[0] !== t2 + LAT) begin
      n_fail++;
      $display("FAIL ferr_time: got cycle %0d, required %0d", fe_cyc_q[0], t2 + LAT);
    end
    check_valid("ferr_before", 0, t1 + LAT, 8'h31);
    n_tests++;
    if (u_if.Keystroke !== 8'h31) begin
      n_fail++;
      $display("FAIL ferr_hold: got %h, required 31", u_if.Keystroke);
    end
    t3 = cyc;
    send_frame(8'h33, 1'b1);
    wait_cycles(16);
    check_valid("ferr_after", 1, t3 + LAT, 8'h33);
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [9:0] bits;
    bits = {1'b1, 8'h32, 1'b0};
    clear_log();
    for (int i = 0; i < 10; i++) begin
      u_if.RX = bits[i];
      for (int c = 0; c < CPB; c++) begin
        rst = (i == 5 && c == 3);
        wait_cycles(1);
      end
    end
    rst     = 1'b0;
    u_if.RX = 1'b1;
    n_tests++;
    if (val_cyc_q.size() + fe_cyc_q.size() !== 0 || u_if.Keystroke !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_abandon: got %0d strobes key %h, required 0 strobes key 00",
               val_cyc_q.size() + fe_cyc_q.size(), u_if.Keystroke);
    end
    // the tail of the cut frame may be re-framed; let it drain before the next byte
    wait_cycles(120);
    clear_log();
    t0 = cyc;
    send_frame(8'h33, 1'b1);
    wait_cycles(16);
    n_tests++;
    if (val_cyc_q.size() !== 1 || fe_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d valid %0d ferr, required 1 valid 0 ferr",
               val_cyc_q.size(), fe_cyc_q.size());
    end
    check_valid("rstmid_next", 0, t0 + LAT, 8'h33);
  endtask

  initial begin
    u_if.RX = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    n_tests++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles, required 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keystroke_uart_rx.md
# keystroke_uart_rx

UART 8N1 receiver that produces the 8-bit keystroke code consumed by the VGA pattern generator. It sits between the board's serial RX pin and the pattern generator's `Keystroke` input. It deserialises ASCII characters sent from a host terminal and holds the last good byte as a level. It also emits a one-cycle strobe per received byte, plus a framing-error strobe.

## Interface
- `CLKS_PER_BIT`, default 217: system clocks per UART bit (25 MHz / 115200). Legal range 4..65535.
- `CLK`  input  1  system clock; all logic is on its rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `RX`  input  1  asynchronous serial line; idles high.
- `Keystroke`  output  8  last correctly framed byte; holds its value between frames.
- `Keystroke_Valid`  output  1  one-cycle pulse when `Keystroke` is updated.
- `Framing_Error`  output  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- `RX` passes through a 2-flop synchroniser; both flops reset to 1. All decisions below use the synchronised signal `rx_s`.
- The bit counter is `$clog2(CLKS_PER_BIT)` wide. The data bit index is 3 bits. The shift register is 8 bits, LSB first.
- Define `HALF = (CLKS_PER_BIT-1)/2` (integer divide).
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** counter = 0. On `rx_s == 0`, go to START.
  - **START:** count up. At count == HALF, sample `rx_s`:
    - If 0, clear the counter, set index = 0, and go to DATA.
    - If 1, treat it as a glitch and return to IDLE. No output changes.
  - **DATA:** count up. At count == CLKS_PER_BIT-1, sample `rx_s` into bit[index] and clear the counter.
    - After index 7 is sampled, go to STOP. Otherwise increment the index.
  - **STOP:** count up. At count == CLKS_PER_BIT-1, sample `rx_s`:
    - If 1, load `Keystroke` from the shift register and pulse `Keystroke_Valid`.
    - If 0, pulse `Framing_Error` and leave `Keystroke` unchanged.
    - In either case, go to IDLE.
- Samples therefore fall at mid-bit: HALF cycles after the start edge, then every CLKS_PER_BIT cycles.
- A line held low (break condition) gives one framing error. After that, IDLE immediately sees `rx_s == 0` and re-enters START. It keeps reporting framing errors, one per frame period, until the line goes high.
- `Keystroke_Valid` and `Framing_Error` are never high in the same cycle.
- **Reset:** `Keystroke` = 8'h00, `Keystroke_Valid` = 0, `Framing_Error` = 0, FSM = IDLE, counters = 0, synchroniser = 1.
  - Reset mid-frame abandons the frame with no pulse.
  - A frame whose start bit begins after `RST` deasserts is received normally.

## Timing
- Take cycle 0 as the first cycle `rx_s` is low in IDLE. START is entered at cycle 1.
- Latency from `RX` pin to `rx_s` is 2 cycles.
- The start sample is taken at cycle 1+HALF.
- Data bit k (k = 0..7) is sampled at cycle 1+HALF+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at cycle 1+HALF+9·CLKS_PER_BIT.
- The `Keystroke` update and the `Keystroke_Valid`/`Framing_Error` pulse are registered. They are visible in the cycle after the stop sample, for exactly one cycle.
- FSM is back in IDLE in that same cycle, so a start edge from a back-to-back frame is detected. The receiver tolerates ±HALF cycles of stop-bit shortening.
- Sustained throughput: one byte per 10·CLKS_PER_BIT cycles.

## Test plan
All scenarios use `CLKS_PER_BIT = 8`; bit period is 8 clocks.

1. **Reset values:** hold `RST` for 3 cycles with `RX` = 1.
   - Required: `Keystroke` = 0x00 and both strobes 0 throughout. No pulse for 200 cycles after release.
2. **Single byte:** send 0x31 ('1').
   - Required: `Keystroke` = 0x31 with `Keystroke_Valid` high for exactly 1 cycle.
   - The pulse lands 2+1+3+72+1 = 79 cycles after the `RX` falling edge.
   - `Keystroke` holds 0x31 afterwards.
3. **Back-to-back:** send 0x31, 0x32, 0x33 with no idle gap, then 0x41.
   - Required: three valid pulses 80 cycles apart, with `Keystroke` = 0x31, 0x32, 0x33 in order.
   - Then `Keystroke` = 0x41, 80 cycles after the 0x33 pulse.
4. **Glitch rejection:** drive `RX` low for 2 cycles, then high.
   - Required: no strobe, `Keystroke` unchanged, FSM back in IDLE.
   - A following 0x32 is received correctly.
5. **Framing error:** after 0x31 is received, send 0x55 with the stop bit driven 0.
   - Required: one `Framing_Error` pulse, no `Keystroke_Valid`, `Keystroke` stays 0x31.
   - A following 0x33 gives a valid pulse and `Keystroke` = 0x33.
6. **Reset mid-frame:** pulse `RST` for 1 cycle during data bit 4 of 0x32.
   - Required: `Keystroke` = 0x00 and no strobe for the rest of that frame.
   - The next frame, 0x33, gives `Keystroke` = 0x33 with one valid pulse.
